// File: rtl/loop_uhat_sparse_udiv_89ns_6ns_seq_if.sv
// Request/result bundle for the loop_uhat_sparse 89/6 sequential divider.
// The master issues operands with start; the slave returns quotient/remainder with done.
interface loop_uhat_sparse_udiv_89ns_6ns_seq_if #(
  parameter int unsigned DIVIDEND_WIDTH = 89,
  parameter int unsigned DIVISOR_WIDTH  = 6,
  parameter int unsigned QUOT_WIDTH     = 83
);
  logic                      start;
  logic [DIVIDEND_WIDTH-1:0] dividend;
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic                      ready;
  logic                      done;
  logic [QUOT_WIDTH-1:0]     quotient;
  logic [DIVISOR_WIDTH-1:0]  remainder;
  logic                      ovf;
  logic                      dbz;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, ovf, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, ovf, dbz
  );
endinterface

// File: rtl/loop_uhat_sparse_udiv_89ns_6ns_seq.sv
// Radix-2 restoring unsigned divider recovering a and remainder from the 83x6->89
// loop_uhat_sparse product; one quotient bit per enabled cycle, results held until next done.
module loop_uhat_sparse_udiv_89ns_6ns_seq #(
  parameter int unsigned ID             = 1,
  parameter int unsigned DIVIDEND_WIDTH = 89,
  parameter int unsigned DIVISOR_WIDTH  = 6,
  parameter int unsigned QUOT_WIDTH     = 83
) (
  input logic clk,
  input logic reset,
  input logic ce,
  loop_uhat_sparse_udiv_89ns_6ns_seq_if.slave bus
);

  localparam int unsigned DW = DIVIDEND_WIDTH;
  localparam int unsigned VW = DIVISOR_WIDTH;
  localparam int unsigned QW = QUOT_WIDTH;
  localparam int unsigned PW = VW + 1;           // partial remainder
  localparam int unsigned SW = PW + 1;           // partial remainder after shift-in
  localparam int unsigned CW = $clog2(DW) + 1;   // MSB flags "all iterations done"

  // Instance tag carries no logic.
  if (ID == 0) begin : g_untagged
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   dq_q, dq_d;        // dividend shifts out the top, quotient shifts in the bottom
  logic [PW-1:0]   prem_q, prem_d;
  logic [VW-1:0]   dsr_q, dsr_d;
  logic            zero_q, zero_d;
  logic [VW-1:0]   lo_q, lo_d;        // dividend low bits for the divide-by-zero remainder
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            ready_q;
  logic            done_q;
  logic [QW-1:0]   quot_q, quot_d;
  logic [VW-1:0]   rem_q, rem_d;
  logic            ovf_q, ovf_d;
  logic            dbz_q, dbz_d;

  logic [SW-1:0]   rem_sh;
  logic            q_bit;

  // Next-state, datapath step and result capture
  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    prem_d  = prem_q;
    dsr_d   = dsr_q;
    zero_d  = zero_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;

    rem_sh  = {prem_q, dq_q[DW-1]};
    q_bit   = (rem_sh >= SW'(dsr_q));

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_CALC;
          dq_d    = bus.dividend;
          prem_d  = '0;
          dsr_d   = bus.divisor;
          zero_d  = (bus.divisor == '0);
          lo_d    = bus.dividend[VW-1:0];
          cnt_d   = CW'(DW - 1);
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CALC: begin
        if (cnt_q[CW-1]) begin
          state_d = S_DONE;
          quot_d  = zero_q ? '1 : dq_q[QW-1:0];
          rem_d   = zero_q ? lo_q : prem_q[VW-1:0];
          ovf_d   = zero_q | (|dq_q[DW-1:QW]);
          dbz_d   = zero_q;
        end else begin
          dq_d    = {dq_q[DW-2:0], q_bit};
          prem_d  = q_bit ? PW'(rem_sh - SW'(dsr_q)) : PW'(rem_sh);
          cnt_d   = cnt_q - CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; ce freezes everything except reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dq_q    <= '0;
      prem_q  <= '0;
      dsr_q   <= '0;
      zero_q  <= 1'b0;
      lo_q    <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      dq_q    <= dq_d;
      prem_q  <= prem_d;
      dsr_q   <= dsr_d;
      zero_q  <= zero_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d != S_CALC);
      done_q  <= (state_d == S_DONE);
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbz       = dbz_q;

endmodule

// File: doc/loop_uhat_sparse_udiv_89ns_6ns_seq.md
Name: loop_uhat_sparse_udiv_89ns_6ns_seq

Overview:
Sequential unsigned divider that is the inverse of the loop_uhat_sparse 83x6->89 product path. It recovers the quotient and remainder from an 89-bit product and a 6-bit factor. It uses a radix-2 restoring algorithm that resolves one quotient bit per enabled cycle, with a start/ready/done handshake and a clock-enable stall. It sits beside the pipelined multiplier in the loop_uhat_sparse datapath.

Parameters:
ID, 1, instance tag; no functional effect
DIVIDEND_WIDTH, 89, dividend width (product width)
DIVISOR_WIDTH, 6, divisor width
QUOT_WIDTH, 83, output quotient width; wider quotient bits feed the overflow flag

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
ce  in  1  clock enable; when 0, all state (including handshake outputs) holds
start  in  1  request; accepted only when ce=1 and ready=1
dividend  in  DIVIDEND_WIDTH  unsigned dividend; sampled on accept
divisor  in  DIVISOR_WIDTH  unsigned divisor; sampled on accept
ready  out  1  high in IDLE and DONE
done  out  1  one-cycle pulse; results valid
quotient  out  QUOT_WIDTH  low QUOT_WIDTH bits of the true quotient
remainder  out  DIVISOR_WIDTH  true remainder
ovf  out  1  true quotient >= 2^QUOT_WIDTH, or divisor was zero
dbz  out  1  divisor was zero

Behaviour:
- Reset (reset=0 at a rising edge): state=IDLE; ready=1; done=0; quotient, remainder, ovf and dbz = 0. Reset applies regardless of ce and aborts any operation in flight.
- States: IDLE, CALC, DONE.
  - IDLE/DONE + accept -> CALC. On accept, register the dividend into a shift register, zero the partial remainder (DIVISOR_WIDTH+1 bits), load the iteration counter with DIVIDEND_WIDTH-1, and latch divisor==0.
  - CALC, each ce cycle:
    - shift the partial remainder left, bringing in the dividend MSB;
    - trial-subtract the divisor; if the result is non-negative, keep the difference and shift in quotient bit 1, else restore and shift in 0;
    - decrement the counter.
  - CALC at counter==0 (after the last iteration) -> DONE.
  - DONE lasts one ce cycle: done=1; a new accept in that cycle goes directly to CALC; otherwise -> IDLE.
- Latency: accept at ce-edge N gives done=1 after edge N+DIVIDEND_WIDTH+1, i.e. 90 enabled cycles with defaults. Each ce=0 cycle extends latency by one.
- quotient, remainder, ovf and dbz update only when entering DONE and hold until the next DONE or reset. They never show intermediate values.
- Internal quotient register is DIVIDEND_WIDTH bits wide. ovf = OR of bits [DIVIDEND_WIDTH-1:QUOT_WIDTH] OR dbz.
- Divide by zero: the iteration runs normally, then outputs are forced to quotient = all ones, remainder = dividend[DIVISOR_WIDTH-1:0], dbz=1, ovf=1. Latency is unchanged.
- A start while busy (CALC) is ignored and not queued. Inputs are not sampled except on accept.
- No combinational path from any input to any output. ready is a function of state only.

Test Plan:
- Basic: reset, then dividend=1000, divisor=7 -> done exactly 90 cycles after accept; quotient=142, remainder=6, ovf=0, dbz=0.
- Round trip with the multiplier: dividend=5*2^82+3, divisor=5 -> quotient=2^82, remainder=3, ovf=0. A random sweep of a<2^83, b in 1..63 with dividend=a*b must return quotient=a, remainder=0.
- Overflow: dividend=2^89-1, divisor=63 -> remainder=31, ovf=1, quotient = low 83 bits of (2^89-32)/63. Also dividend=2^89-1, divisor=1 -> quotient=2^83-1, remainder=0, ovf=1.
- Divide by zero: dividend=123, divisor=0 -> quotient=2^83-1, remainder=59, dbz=1, ovf=1, latency 90.
- Stall/back-to-back: toggle ce 0/1 every 3 cycles during CALC -> latency = 90 + number of ce=0 cycles, same result. Start with new operands in the done cycle -> second done exactly 90 enabled cycles later. Start pulsed mid-CALC -> ignored.
- Reset mid-operation: reset=0 at iteration 40 -> next edge IDLE, ready=1, all outputs 0, no done. A following request completes correctly.
